// File: rtl/mpu_regfile_if.sv
// Bus between the MPU load/store/compute stages and the matrix register file.
// The master side drives load beats, clears and reads; the slave side is the register file.
interface mpu_regfile_if #(
    parameter int FP              = 32,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_SIZE = 3
);
    logic                          reg_load_en_in;
    logic [MATRIX_REG_SIZE-1:0]    reg_load_addr_in;
    logic [FP-1:0]                 reg_load_element_in;
    logic [MBITS:0]                reg_i_load_loc_in;
    logic [NBITS:0]                reg_j_load_loc_in;
    logic [MBITS:0]                reg_m_load_size_in;
    logic [NBITS:0]                reg_n_load_size_in;
    logic                          reg_load_error_out;
    logic                          clr_en_in;
    logic [MATRIX_REG_SIZE-1:0]    clr_addr_in;
    logic                          rd_en_in;
    logic [MATRIX_REG_SIZE-1:0]    rd_addr_in;
    logic [MBITS:0]                rd_i_in;
    logic [NBITS:0]                rd_j_in;
    logic                          rd_valid_out;
    logic                          rd_error_out;
    logic [FP-1:0]                 rd_element_out;
    logic [MBITS:0]                rd_m_size_out;
    logic [NBITS:0]                rd_n_size_out;
    logic [2**MATRIX_REG_SIZE-1:0] reg_valid_out;

    modport master (
        output reg_load_en_in, reg_load_addr_in, reg_load_element_in,
        output reg_i_load_loc_in, reg_j_load_loc_in, reg_m_load_size_in, reg_n_load_size_in,
        output clr_en_in, clr_addr_in, rd_en_in, rd_addr_in, rd_i_in, rd_j_in,
        input  reg_load_error_out, rd_valid_out, rd_error_out, rd_element_out,
        input  rd_m_size_out, rd_n_size_out, reg_valid_out
    );

    modport slave (
        input  reg_load_en_in, reg_load_addr_in, reg_load_element_in,
        input  reg_i_load_loc_in, reg_j_load_loc_in, reg_m_load_size_in, reg_n_load_size_in,
        input  clr_en_in, clr_addr_in, rd_en_in, rd_addr_in, rd_i_in, rd_j_in,
        output reg_load_error_out, rd_valid_out, rd_error_out, rd_element_out,
        output rd_m_size_out, rd_n_size_out, reg_valid_out
    );
endinterface

// File: rtl/mpu_regfile.sv
// Matrix register file: accepts a row-major element stream per matrix, tracks
// EMPTY/FILLING/VALID per register and serves one registered element read per cycle.
module mpu_regfile #(
    parameter int FP              = 32,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_SIZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    mpu_regfile_if.slave bus
);
    localparam int R  = 2**MATRIX_REG_SIZE;
    localparam int AW = MATRIX_REG_SIZE + MBITS + NBITS;
    localparam logic [MBITS:0] M_MAX = M[MBITS:0];
    localparam logic [NBITS:0] N_MAX = N[NBITS:0];
    localparam logic [MBITS:0] ONE_I = {{MBITS{1'b0}}, 1'b1};
    localparam logic [NBITS:0] ONE_J = {{NBITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {EMPTY, FILLING, VALID} reg_state_e;

    reg_state_e                 state_q [R];
    reg_state_e                 state_d [R];
    logic [MBITS:0]             m_size_q [R];
    logic [MBITS:0]             m_size_d [R];
    logic [NBITS:0]             n_size_q [R];
    logic [NBITS:0]             n_size_d [R];
    logic [MATRIX_REG_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [MBITS:0]             exp_i_q, exp_i_d;
    logic [NBITS:0]             exp_j_q, exp_j_d;
    logic                       load_err_q, load_err_d;
    logic                       rd_valid_q, rd_valid_d;
    logic                       rd_error_q, rd_error_d;
    logic [FP-1:0]              rd_element_q, rd_element_d;
    logic [MBITS:0]             rd_m_q, rd_m_d;
    logic [NBITS:0]             rd_n_q, rd_n_d;

    logic [FP-1:0]              mem_q [2**AW];
    logic                       start_ok, cont_ok, store_en, last_beat, rd_hit;
    logic [AW-1:0]              wr_idx, rd_idx;
    logic [R-1:0]               valid_vec;

    // Beat classification against the single fill tracker.
    always_comb begin
        start_ok = bus.reg_load_en_in
                && bus.reg_i_load_loc_in == '0 && bus.reg_j_load_loc_in == '0
                && bus.reg_m_load_size_in != '0 && bus.reg_m_load_size_in <= M_MAX
                && bus.reg_n_load_size_in != '0 && bus.reg_n_load_size_in <= N_MAX;
        cont_ok  = bus.reg_load_en_in && !start_ok
                && bus.reg_load_addr_in == wr_addr_q
                && state_q[bus.reg_load_addr_in] == FILLING
                && bus.reg_i_load_loc_in == exp_i_q && bus.reg_j_load_loc_in == exp_j_q
                && bus.reg_m_load_size_in == m_size_q[bus.reg_load_addr_in]
                && bus.reg_n_load_size_in == n_size_q[bus.reg_load_addr_in];
        store_en  = start_ok || cont_ok;
        last_beat = bus.reg_i_load_loc_in == bus.reg_m_load_size_in - ONE_I
                 && bus.reg_j_load_loc_in == bus.reg_n_load_size_in - ONE_J;
        wr_idx = {bus.reg_load_addr_in, bus.reg_i_load_loc_in[MBITS-1:0],
                  bus.reg_j_load_loc_in[NBITS-1:0]};
    end

    always_comb begin
        state_d    = state_q;
        m_size_d   = m_size_q;
        n_size_d   = n_size_q;
        wr_addr_d  = wr_addr_q;
        exp_i_d    = exp_i_q;
        exp_j_d    = exp_j_q;
        load_err_d = bus.reg_load_en_in && !store_en;

        // A write to the same register wins over a simultaneous clear.
        if (bus.clr_en_in && !(bus.reg_load_en_in && bus.clr_addr_in == bus.reg_load_addr_in))
            state_d[bus.clr_addr_in] = EMPTY;

        if (start_ok) begin
            for (int k = 0; k < R; k++)
                if (state_q[k] == FILLING) state_d[k] = EMPTY;
            m_size_d[bus.reg_load_addr_in] = bus.reg_m_load_size_in;
            n_size_d[bus.reg_load_addr_in] = bus.reg_n_load_size_in;
            wr_addr_d = bus.reg_load_addr_in;
        end

        if (store_en) begin
            state_d[bus.reg_load_addr_in] = last_beat ? VALID : FILLING;
            if (bus.reg_j_load_loc_in == bus.reg_n_load_size_in - ONE_J) begin
                exp_j_d = '0;
                exp_i_d = bus.reg_i_load_loc_in + ONE_I;
            end else begin
                exp_j_d = bus.reg_j_load_loc_in + ONE_J;
                exp_i_d = bus.reg_i_load_loc_in;
            end
        end else if (bus.reg_load_en_in && state_q[wr_addr_q] == FILLING) begin
            state_d[wr_addr_q] = EMPTY;
        end
    end

    // Reads see pre-write state; array locations outside a VALID fill never leak out.
    always_comb begin
        rd_idx = {bus.rd_addr_in, bus.rd_i_in[MBITS-1:0], bus.rd_j_in[NBITS-1:0]};
        rd_hit = state_q[bus.rd_addr_in] == VALID
              && bus.rd_i_in < m_size_q[bus.rd_addr_in]
              && bus.rd_j_in < n_size_q[bus.rd_addr_in];
        rd_valid_d   = bus.rd_en_in && rd_hit;
        rd_error_d   = bus.rd_en_in && !rd_hit;
        rd_element_d = rd_valid_d ? mem_q[rd_idx] : '0;
        rd_m_d       = rd_valid_d ? m_size_q[bus.rd_addr_in] : '0;
        rd_n_d       = rd_valid_d ? n_size_q[bus.rd_addr_in] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < R; k++) begin
                state_q[k]  <= EMPTY;
                m_size_q[k] <= '0;
                n_size_q[k] <= '0;
            end
            wr_addr_q    <= '0;
            exp_i_q      <= '0;
            exp_j_q      <= '0;
            load_err_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_error_q   <= 1'b0;
            rd_element_q <= '0;
            rd_m_q       <= '0;
            rd_n_q       <= '0;
        end else begin
            state_q      <= state_d;
            m_size_q     <= m_size_d;
            n_size_q     <= n_size_d;
            wr_addr_q    <= wr_addr_d;
            exp_i_q      <= exp_i_d;
            exp_j_q      <= exp_j_d;
            load_err_q   <= load_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_error_q   <= rd_error_d;
            rd_element_q <= rd_element_d;
            rd_m_q       <= rd_m_d;
            rd_n_q       <= rd_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) mem_q[wr_idx] <= bus.reg_load_element_in;
    end

    always_comb begin
        for (int k = 0; k < R; k++) valid_vec[k] = state_q[k] == VALID;
    end

    assign bus.reg_valid_out      = valid_vec;
    assign bus.reg_load_error_out = load_err_q;
    assign bus.rd_valid_out       = rd_valid_q;
    assign bus.rd_error_out       = rd_error_q;
    assign bus.rd_element_out     = rd_element_q;
    assign bus.rd_m_size_out      = rd_m_q;
    assign bus.rd_n_size_out      = rd_n_q;
endmodule

// File: doc/mpu_regfile.md
# mpu_regfile

Matrix register file sitting directly downstream of the MPU load stage. It stores up to 2**MATRIX_REG_SIZE matrices of at most M×N FP-bit elements. It accepts the load stage's row-major element stream, one element per cycle, and tracks per-register fill state and dimensions. It serves one registered element read per cycle to the store and compute stages.

## Interface
- FP, 32, element width in bits
- M, 4, maximum rows
- N, 4, maximum columns
- MBITS, 2, clog2(M); row fields are MBITS+1 bits wide
- NBITS, 2, clog2(N); column fields are NBITS+1 bits wide
- MATRIX_REG_SIZE, 3, register address width; R = 2**MATRIX_REG_SIZE registers
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- reg_load_en_in  in  1  write beat valid
- reg_load_addr_in  in  MATRIX_REG_SIZE  target register
- reg_load_element_in  in  FP  element data
- reg_i_load_loc_in  in  MBITS+1  row of beat
- reg_j_load_loc_in  in  NBITS+1  column of beat
- reg_m_load_size_in  in  MBITS+1  matrix rows
- reg_n_load_size_in  in  NBITS+1  matrix columns
- reg_load_error_out  out  1  one-cycle pulse: beat rejected
- clr_en_in  in  1  invalidate request
- clr_addr_in  in  MATRIX_REG_SIZE  register to invalidate
- rd_en_in  in  1  read request
- rd_addr_in  in  MATRIX_REG_SIZE  register to read
- rd_i_in  in  MBITS+1  row to read
- rd_j_in  in  NBITS+1  column to read
- rd_valid_out  out  1  read data valid, one cycle
- rd_error_out  out  1  read rejected, one cycle
- rd_element_out  out  FP  read data
- rd_m_size_out  out  MBITS+1  rows of read register
- rd_n_size_out  out  NBITS+1  columns of read register
- reg_valid_out  out  R  bit k set when register k is VALID

## Operation
- Each register has a state of EMPTY, FILLING or VALID, plus stored m/n sizes.
- One fill tracker holds wr_addr_q, exp_i and exp_j, because the load stage fills one matrix at a time.
- **Start beat:** a beat with i=0, j=0, 1≤m≤M and 1≤n≤N is accepted. Any register in any state moves to FILLING. The tracker loads the beat's address, sizes are latched, and the element is stored. Any other register still FILLING is aborted to EMPTY.
- **Continue beat:** accepted when the address equals wr_addr_q, the register is FILLING, the beat is at (exp_i, exp_j), and m/n match the latched sizes.
- The expected position advances row-major: j wraps at n-1 to 0 and i then increments.
- **Completion:** when the beat at (m-1, n-1) is accepted, the register moves to VALID.
- A 1×1 matrix goes from EMPTY to VALID on its single start beat.
- **Rejected beat:** any beat that is neither an accepted start nor an accepted continue is rejected.
  - The element is not stored.
  - reg_load_error_out pulses.
  - The tracked register, if FILLING, moves to EMPTY.
- **Clear:** sets the register to EMPTY.
  - If a write beat targets the same address in the same cycle, the clear is ignored and the write proceeds.
- **Read:** returns the element and sizes of a VALID register when i<m and j<n.
  - Otherwise rd_error_out is set and rd_element_out and both size outputs are 0.
- **Read/write same cycle:** the read observes the state and data from before that cycle's write.
- Storage array is not reset. Any location outside the current fill is never returned as data.

## Timing
- **Reset (asynchronous, rst low):**
  - all registers go to EMPTY and the tracker is cleared;
  - reg_valid_out = 0;
  - reg_load_error_out, rd_valid_out and rd_error_out = 0;
  - rd_element_out, rd_m_size_out and rd_n_size_out = 0.
- A reset mid-fill aborts the fill; the next valid beat must be a start beat.
- **Write:** a beat at edge t is stored at edge t.
  - The reg_valid_out bit rises in the cycle after the final beat's edge.
  - reg_load_error_out is registered and high for the one cycle after a rejected beat.
- **Read latency:** 1 cycle. rd_en_in sampled at edge t gives rd_valid_out or rd_error_out, plus data, during cycle t+1. Both flags are low otherwise.
- Back-to-back reads every cycle are supported.
- rd_valid_out and rd_error_out are never high together.
- No backpressure: every beat is accepted or rejected in its own cycle.

## Test plan
- Reset, then a 2×3 fill of reg 5 with elements 0x3F800000..0x40C00000 → reg_valid_out=0x20 one cycle after the last beat. Reading (1,2) returns 0x40C00000, m=2, n=3, one cycle later.
- Read reg 5 while it is FILLING (after 3 of 6 beats) → rd_error_out=1, rd_element_out=0. Read (2,0) of VALID 2×3 reg 5 → rd_error_out=1.
- Out-of-order beat (1,0) sent where (0,2) is expected during a fill of reg 1 → reg_load_error_out pulses and reg 1 goes EMPTY. A new start beat then fills reg 1 normally.
- Start beat with m=5 (M=4), or with m=0 → error pulse, no state change. A 1×1 fill of reg 0 → bit 0 set after one beat.
- Clear reg 2 in the same cycle as a start beat to reg 2 → fill proceeds. A clear alone on VALID reg 2 → bit 2 drops next cycle.
- rst low mid-fill of reg 3 with VALID reg 4 → reg_valid_out=0 immediately. A continue beat after release → error pulse.
